// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state type and the instruction constants
// that decode/control also match against.
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;
  localparam int IFID_W  = INSTR_W + PC_W + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [INSTR_W-1:0] INT_INSTR = 16'hF800;
  localparam logic [PC_W-1:0]    BOOT_ADDR = 32'd0;

  typedef enum logic [1:0] {
    BOOT_HI,
    BOOT_LO,
    RUN,
    INT_WAIT
  } fetch_state_t;

endpackage

// File: rtl/var_reg.sv
// Generic load-enabled register with synchronous active-high clear.
module var_reg #(
  parameter int SIZE = 49
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boots PC from a two-word vector, then fetches one word per
// cycle into IF/ID with stall/flush/redirect handling and interrupt injection.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                  PC_W      = fetch_pkg::PC_W,
  parameter int                  INSTR_W   = fetch_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter logic [INSTR_W-1:0]  INT_INSTR = fetch_pkg::INT_INSTR,
  parameter logic [PC_W-1:0]     BOOT_ADDR = fetch_pkg::BOOT_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               interrupt,
  input  logic               stall,
  input  logic               flush,
  input  logic               jump_taken,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               pc_choose_memory,
  input  logic [PC_W-1:0]    mem_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    PC,
  output logic               interrupt_signal
);

  localparam int W = INSTR_W + PC_W + 1;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [INSTR_W-1:0] hi_q, hi_d;
  logic               int_pending_q, inject;

  logic               ifid_en;
  logic [INSTR_W-1:0] instr_p0;
  logic [PC_W-1:0]    pc_p0;
  logic               int_p0;
  logic [W-1:0]       ifid_p1;

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    case (state_q)
      BOOT_HI: imem_addr = BOOT_ADDR;
      BOOT_LO: imem_addr = BOOT_ADDR + PC_W'(1);
      default: imem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hi_d     = hi_q;
    inject   = 1'b0;
    ifid_en  = 1'b1;
    instr_p0 = NOP_INSTR;
    pc_p0    = '0;
    int_p0   = 1'b0;
    case (state_q)
      BOOT_HI: begin
        hi_d    = imem_data;
        state_d = BOOT_LO;
      end
      BOOT_LO: begin
        pc_d    = PC_W'({hi_q, imem_data});
        state_d = RUN;
      end
      RUN: begin
        if (pc_choose_memory) begin
          pc_d = mem_pc;
        end else if (jump_taken) begin
          pc_d = jump_target;
        end else if (stall) begin
          // A flush during a stall still squashes IF/ID; the PC stays put.
          ifid_en = flush;
        end else if (flush) begin
          pc_d = pc_inc;
        end else if (int_pending_q) begin
          inject   = 1'b1;
          instr_p0 = INT_INSTR;
          pc_p0    = pc_q;
          int_p0   = 1'b1;
          state_d  = INT_WAIT;
        end else begin
          instr_p0 = imem_data;
          pc_p0    = pc_inc;
          pc_d     = pc_inc;
        end
      end
      INT_WAIT: begin
        // Bubbles only, so the injected entry is never seen twice by decode.
        if (pc_choose_memory) begin
          pc_d    = mem_pc;
          state_d = RUN;
        end
      end
      default: state_d = BOOT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT_HI;
      pc_q          <= '0;
      hi_q          <= '0;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hi_q          <= hi_d;
      int_pending_q <= interrupt | (int_pending_q & ~inject);
    end
  end

  // IF/ID boundary
  var_reg #(.SIZE(W)) u_ifid (
    .clk   (clk),
    .reset (reset),
    .en    (ifid_en),
    .d     ({instr_p0, pc_p0, int_p0}),
    .q     (ifid_p1)
  );

  assign {instruction, PC, interrupt_signal} = ifid_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: per-cycle expected IF/ID entries are queued
// when stimulus is applied and compared after the clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, interrupt, stall, flush, jump_taken, pc_choose_memory;
  logic [31:0] jump_target, mem_pc, imem_addr, PC;
  logic [15:0] imem_data, instruction;
  logic        interrupt_signal;

  logic [15:0] mem [4096];

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
    logic        intsig;
  } ifid_t;

  ifid_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_RST  = 6'b100000;
  localparam logic [5:0] C_INT  = 6'b010000;
  localparam logic [5:0] C_STL  = 6'b001000;
  localparam logic [5:0] C_FL   = 6'b000100;
  localparam logic [5:0] C_JMP  = 6'b000010;
  localparam logic [5:0] C_PCM  = 6'b000001;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] INT = 16'hF800;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[11:0]];

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .interrupt        (interrupt),
    .stall            (stall),
    .flush            (flush),
    .jump_taken       (jump_taken),
    .jump_target      (jump_target),
    .pc_choose_memory (pc_choose_memory),
    .mem_pc           (mem_pc),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .instruction      (instruction),
    .PC               (PC),
    .interrupt_signal (interrupt_signal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive controls, check the fetch address (unless addr_chk=0),
  // queue the expected IF/ID entry, then compare it after the edge.
  task automatic step(input logic [5:0] ctl, input logic [31:0] jt, input logic [31:0] mp,
                      input bit addr_chk, input logic [31:0] exp_addr,
                      input logic [15:0] ei, input logic [31:0] epc, input logic es);
    ifid_t e;
    @(negedge clk);
    {reset, interrupt, stall, flush, jump_taken, pc_choose_memory} = ctl;
    jump_target = jt;
    mem_pc      = mp;
    #1;
    if (addr_chk) chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
    exp_q.push_back('{instr: ei, pc: epc, intsig: es});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("instruction", 64'(instruction), 64'(e.instr));
      chk("PC", 64'(PC), 64'(e.pc));
      chk("interrupt_signal", 64'(interrupt_signal), 64'(e.intsig));
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    step(C_NONE, 0, 0, 1, a, mem[a[11:0]], a + 32'd1, 1'b0);
  endtask

  task automatic bubble(input logic [5:0] ctl, input logic [31:0] jt, input logic [31:0] mp,
                        input logic [31:0] a);
    step(ctl, jt, mp, 1, a, NOP, 32'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 16'h3C01);
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0020;
    mem[12'h20] = 16'h1234;
    {reset, interrupt, stall, flush, jump_taken, pc_choose_memory} = 6'b100000;
    jump_target = 0;
    mem_pc      = 0;

    // Reset and boot
    step(C_RST, 0, 0, 0, 0, NOP, 0, 0);
    bubble(C_NONE, 0, 0, 32'h0);
    bubble(C_NONE, 0, 0, 32'h1);
    step(C_NONE, 0, 0, 1, 32'h20, 16'h1234, 32'h21, 1'b0);
    fetch(32'h21);

    // Stall holds PC and IF/ID for two cycles
    step(C_STL, 0, 0, 1, 32'h22, mem[12'h21], 32'h22, 1'b0);
    step(C_STL, 0, 0, 1, 32'h22, mem[12'h21], 32'h22, 1'b0);
    fetch(32'h22);

    // Memory redirect beats jump
    bubble(C_JMP | C_PCM, 32'h100, 32'h200, 32'h23);
    fetch(32'h200);
    bubble(C_JMP, 32'h30, 0, 32'h201);

    // Stall+flush squashes without advancing; flush alone advances
    bubble(C_STL | C_FL, 0, 0, 32'h30);
    fetch(32'h30);
    bubble(C_FL, 0, 0, 32'h31);
    fetch(32'h32);

    // Interrupt pulse on the jump cycle: injected at 0x40
    bubble(C_JMP | C_INT, 32'h40, 0, 32'h33);
    step(C_NONE, 0, 0, 1, 32'h40, INT, 32'h40, 1'b1);
    bubble(C_JMP | C_FL | C_INT, 32'h999, 0, 32'h40);
    bubble(C_STL | C_INT, 0, 0, 32'h40);
    bubble(C_NONE, 0, 0, 32'h40);
    bubble(C_PCM, 0, 32'h500, 32'h40);
    // Collapsed INT_WAIT requests: injected once on return
    step(C_NONE, 0, 0, 1, 32'h500, INT, 32'h500, 1'b1);
    bubble(C_PCM, 0, 32'h60, 32'h500);
    fetch(32'h60);
    fetch(32'h61);

    // PC wrap
    bubble(C_JMP, 32'hFFFF_FFFF, 0, 32'h62);
    step(C_NONE, 0, 0, 1, 32'hFFFF_FFFF, mem[12'hFFF], 32'h0, 1'b0);
    step(C_NONE, 0, 0, 1, 32'h0, mem[0], 32'h1, 1'b0);

    // Interrupt during boot: serviced on first RUN cycle
    step(C_RST, 0, 0, 0, 0, NOP, 0, 0);
    bubble(C_INT, 0, 0, 32'h0);
    bubble(C_NONE, 0, 0, 32'h1);
    step(C_NONE, 0, 0, 1, 32'h20, INT, 32'h20, 1'b1);
    bubble(C_NONE, 0, 0, 32'h20);

    // Reset in INT_WAIT with a concurrent request drops everything
    step(C_RST | C_INT, 0, 0, 1, 32'h20, NOP, 0, 0);
    bubble(C_NONE, 0, 0, 32'h0);
    bubble(C_NONE, 0, 0, 32'h1);
    step(C_NONE, 0, 0, 1, 32'h20, 16'h1234, 32'h21, 1'b0);
    fetch(32'h21);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. It owns the 32-bit PC and boots the PC from a vector in instruction memory. It fetches one 16-bit word per cycle into the IF/ID pipeline register, which supplies decode with instruction, PC and interrupt_signal. It also handles stall, flush, jump and memory-sourced PC redirects, and injects an interrupt pseudo-instruction.

Parameters:
PC_W, 32, PC / address width
INSTR_W, 16, instruction word width
NOP_INSTR, 16'h0000, bubble word written into IF/ID
INT_INSTR, 16'hF800, pseudo-instruction injected on interrupt
BOOT_ADDR, 0, address of vector high half (low half at BOOT_ADDR+1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
interrupt  in  1  external interrupt request (pulse or level)
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  write NOP_INSTR into IF/ID
jump_taken  in  1  branch/jump resolved taken
jump_target  in  32  target for jump_taken
pc_choose_memory  in  1  load PC from memory stage (RET/RTI/interrupt vector)
mem_pc  in  32  PC value from memory stage
imem_addr  out  32  combinational instruction-memory address
imem_data  in  16  combinational read data for imem_addr
instruction  out  16  IF/ID: fetched word
PC  out  32  IF/ID: address of fetched word + 1 (return address)
interrupt_signal  out  1  IF/ID: marks injected INT_INSTR

Behaviour:
- Reset is synchronous, active-high, and clears everything. Cycle after reset: instruction=NOP_INSTR, PC=0, interrupt_signal=0, pc_q=0, int_pending=0, state=BOOT_HI.
- imem_addr is combinational:
  - BOOT_HI: BOOT_ADDR.
  - BOOT_LO: BOOT_ADDR+1.
  - All other states: pc_q.
- FSM states: BOOT_HI, BOOT_LO, RUN, INT_WAIT.
- BOOT_HI: latch hi=imem_data. Go to BOOT_LO. IF/ID <= NOP.
- BOOT_LO: pc_q <= {hi, imem_data}. Go to RUN. IF/ID <= NOP.
- Boot is two cycles. stall, flush, jump_taken and pc_choose_memory are ignored during boot.
- RUN priority, highest first:
  1. pc_choose_memory: pc_q <= mem_pc; IF/ID <= NOP.
  2. jump_taken: pc_q <= jump_target; IF/ID <= NOP.
  3. stall: pc_q and IF/ID hold. If flush is also set, IF/ID <= NOP while pc_q holds.
  4. flush: IF/ID <= NOP; pc_q <= pc_q+1.
  5. int_pending: IF/ID <= {INT_INSTR, PC=pc_q, interrupt_signal=1}; pc_q holds; int_pending <= 0; go to INT_WAIT.
  6. Normal: IF/ID <= {imem_data, pc_q+1, 0}; pc_q <= pc_q+1.
- Fetch latency: imem_data at pc_q appears on instruction one cycle later.
- interrupt_signal is 1 only for the cycle INT_INSTR is in IF/ID, and only when that entry was not stalled.
- INT_WAIT:
  - IF/ID <= NOP and pc_q holds each cycle.
  - jump_taken and flush have no effect on pc_q.
  - pc_choose_memory: pc_q <= mem_pc, go to RUN.
  - stall holds IF/ID (which already holds NOP).
- int_pending is set by interrupt=1 in any non-reset cycle and cleared only on injection. A request during BOOT or INT_WAIT is serviced after the return to RUN. Multiple requests before service collapse into one.
- pc_q+1 wraps 32'hFFFF_FFFF -> 0 with no flag.
- Reset mid-operation, including in INT_WAIT, aborts to BOOT_HI and drops int_pending.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {BOOT_HI, BOOT_LO, RUN, INT_WAIT}
  - NOP_INSTR, INT_INSTR and BOOT_ADDR constants (also used by decode/control for opcode matching)
- The IF/ID register reuses the existing var_reg (size 49: 16+32+1).
- PC/next-PC logic and the FSM stay in fetch_stage. No other sub-module.

Test Plan:
- Boot: M[0]=16'h0000, M[1]=16'h0020, M[0x20]=16'h1234. Assert reset 1 cycle. Required: imem_addr 0, then 1, then 0x20. instruction=NOP for 2 cycles, then 16'h1234 with PC=0x21.
- Sequential plus stall: run from 0x20, stall at 0x22 for 2 cycles. Required: imem_addr stays 0x22 for 2 cycles. IF/ID holds the word from 0x21 (PC=0x22). Fetch resumes at 0x22.
- Jump vs memory priority: jump_taken=1 (target 0x100) and pc_choose_memory=1 (mem_pc 0x200) in the same cycle. Required: next imem_addr=0x200 and instruction=NOP.
- Flush with stall: stall=1, flush=1 at pc_q=0x30. Required: instruction=NOP and imem_addr stays 0x30.
- Interrupt: pulse interrupt at pc_q=0x40. Required:
  - next cycle instruction=16'hF800, PC=0x40, interrupt_signal=1;
  - then NOPs with imem_addr=0x40 until pc_choose_memory with mem_pc=0x500, after which imem_addr=0x500.
- Interrupt during boot/wait: interrupt in BOOT_HI, and a second interrupt in INT_WAIT. Required: the boot request is injected on the first RUN cycle. The INT_WAIT request is injected on the first RUN cycle after return, once only.
